rf_alu_engine: RTL and testbench
================================

# rf_alu_engine

Parametrised register-file + ALU execution engine, the next generation of the 8×8-bit register bank and 5-operation ULA datapath. It adds a valid/ready command interface, an internal 4-state sequencer (read, execute, write-back), immediate operands, three additional ALU operations and registered carry/overflow flags. It sits between a future instruction decoder, or the board-level switch/key test harness, and the LCD/HEX debug outputs. It is the datapath core for the upcoming multicycle processor.

## Interface
- WIDTH, 8: data/register width in bits; legal values ≥ 4.
- NREGS, 8: number of registers; a power of two, ≥ 2.
- AW, $clog2(NREGS): derived register address width; not overridable.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  3  ALU operation, per the encoding in Operation.
- cmd_rd  in  AW  destination register.
- cmd_rs1  in  AW  source A register.
- cmd_rs2  in  AW  source B register.
- cmd_imm  in  WIDTH  immediate operand.
- cmd_use_imm  in  1  when 1, source B is cmd_imm instead of rs2.
- cmd_we  in  1  write the result to rd.
- res_valid  out  1  one-cycle pulse; res_* fields are new.
- res_data  out  WIDTH  last result; holds until the next EXEC.
- res_z, res_c, res_v  out  1 each  zero, carry and signed-overflow flags of the last result.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  WIDTH  combinational read of register dbg_addr.

## Operation
- Op encoding:
  - 000 AND, 001 OR, 010 ADD, 011 XOR.
  - 100 SLL, 101 SRL: shift amount is B[AW_S-1:0], where AW_S = $clog2(WIDTH); zero fill.
  - 110 SUB (A−B).
  - 111 SLT: signed A<B gives 1, else 0; the result is zero-extended.
- r0 is hardwired to zero. Writes to r0 are discarded, but the result and flags are still reported.
- FSM states IDLE, READ, EXEC, WB:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch all cmd_* fields and go to READ.
  - READ: latch A=R[rs1] and B = use_imm ? imm : R[rs2]. Go to EXEC.
  - EXEC: compute the result and register res_data and the flags. Go to WB.
  - WB: if we && rd≠0, R[rd] ← res_data at the end of this cycle. res_valid=1. Go to IDLE.
- cmd_ready is 1 only in IDLE. Command inputs are ignored in all other states.
- Flags:
  - Z = (result == 0) for every op.
  - C = carry-out for ADD; for SUB, C = 1 when there is no borrow (A ≥ B unsigned); C = 0 for all other ops.
  - V = two's-complement overflow for ADD/SUB; V = 0 for all other ops.
- Arithmetic is modulo 2^WIDTH.
- Read-after-write: a command accepted after WB reads the updated register (READ follows WB by at least one cycle).
- dbg_data shows the pre-write value during the WB cycle and the new value from the next cycle.

## Timing
- A command accepted at edge t yields:
  - READ at t+1, EXEC at t+2, WB at t+3 (res_valid=1 during t+3..t+4).
  - IDLE, with cmd_ready=1, from t+4.
- Latency is 3 cycles; throughput is one command per 4 cycles. If cmd_valid is held high, the next command is accepted at edge t+4.
- Reset values:
  - State IDLE, so cmd_ready=1.
  - res_valid=0, res_data=0, res_z=0, res_c=0, res_v=0.
  - All registers 0, so dbg_data=0.
- Reset asserted mid-operation (READ/EXEC/WB) aborts the command: no register write and no res_valid pulse. The engine is in IDLE on the first edge after rst deasserts.
- res_* outputs are stable outside EXEC→WB updates.

## Structure
- Shared package rf_alu_pkg holds:
  - the op enum (ALU_AND…ALU_SLT with the encodings above);
  - the state enum (S_IDLE, S_READ, S_EXEC, S_WB).
- One sub-module, alu_core: purely combinational, parametrised by WIDTH. Inputs are A, B and op; outputs are result, z, c and v.
- Register array, sequencer and handshake live in rf_alu_engine.

## Test plan
- Reset: assert rst mid-stream, then release. Required: cmd_ready=1, res_valid=0, dbg_data=0 for every address.
- Immediates: r1←r0+0x05 (imm) and r2←r0+0x03 (imm), then ADD r3←r1+r2. Required: res_valid at t+3, res_data=0x08, Z=C=V=0, dbg r3=0x08.
- SUB/SLT:
  - SUB r4←r2−r1 gives 0xFE, C=0, V=0.
  - SLT r5←r2,r1 gives 0x01.
  - SUB r1−r1 gives 0x00, Z=1, C=1.
- Flags and shifts:
  - 0x7F+0x01 gives 0x80, V=1, C=0.
  - 0xFF+0x01 gives 0x00, C=1, Z=1.
  - SLL 0x81 by 1 gives 0x02.
  - SRL 0x80 by 7 gives 0x01.
- r0 and back-to-back: ADD targeting r0 reports 0x0A, but dbg r0 stays 0. With cmd_valid held high, the second command is accepted exactly 4 cycles after the first.
- Reset during EXEC of r6←0x55: no res_valid pulse, dbg r6=0, and a command is accepted on the first cycle after release.

Source files
------------

// File: rtl/rf_alu_pkg.sv
// Shared types for the register-file + ALU engine: ALU op encodings and sequencer states.
package rf_alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: eight operations plus zero, carry and signed-overflow flags.
module alu_core
  import rf_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             c,
  output logic             v
);

  localparam int unsigned SW = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SW-1:0]    shamt;
  logic             lt;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SW-1:0];
  assign lt    = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    unique case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_ADD: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result = diff[WIDTH-1:0];
        // Carry means "no borrow", i.e. A >= B unsigned.
        c      = ~diff[WIDTH];
        v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, lt};
      default: result = '0;
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/rf_alu_engine.sv
// Register file + ALU engine: valid/ready command in, four-state READ/EXEC/WB sequencer,
// registered result and flags, r0 hardwired to zero.
module rf_alu_engine
  import rf_alu_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned NREGS = 8,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_rs1,
  input  logic [AW-1:0]    cmd_rs2,
  input  logic [WIDTH-1:0] cmd_imm,
  input  logic             cmd_use_imm,
  input  logic             cmd_we,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_z,
  output logic             res_c,
  output logic             res_v,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  state_e           state_q;
  alu_op_e          op_q;
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    rs1_q;
  logic [AW-1:0]    rs2_q;
  logic [WIDTH-1:0] imm_q;
  logic             use_imm_q;
  logic             we_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] regs [NREGS];

  logic [WIDTH-1:0] alu_result;
  logic             alu_z;
  logic             alu_c;
  logic             alu_v;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .result(alu_result),
    .z     (alu_z),
    .c     (alu_c),
    .v     (alu_v)
  );

  // regs[0] is never written, so it reads as zero without a special case.
  assign dbg_data = regs[dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_z     <= 1'b0;
      res_c     <= 1'b0;
      res_v     <= 1'b0;
      op_q      <= ALU_AND;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      we_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q      <= alu_op_e'(cmd_op);
            rd_q      <= cmd_rd;
            rs1_q     <= cmd_rs1;
            rs2_q     <= cmd_rs2;
            imm_q     <= cmd_imm;
            use_imm_q <= cmd_use_imm;
            we_q      <= cmd_we;
            cmd_ready <= 1'b0;
            state_q   <= S_READ;
          end
        end
        S_READ: begin
          a_q     <= regs[rs1_q];
          b_q     <= use_imm_q ? imm_q : regs[rs2_q];
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          res_data  <= alu_result;
          res_z     <= alu_z;
          res_c     <= alu_c;
          res_v     <= alu_v;
          res_valid <= 1'b1;
          state_q   <= S_WB;
        end
        S_WB: begin
          if (we_q && (rd_q != '0)) begin
            regs[rd_q] <= res_data;
          end
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: begin
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_alu_engine.sv
// Directed bench for rf_alu_engine: handshake timing, ALU results/flags, r0, reset abort.
module tb_rf_alu_engine;
  import rf_alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_rd;
  logic [2:0] cmd_rs1;
  logic [2:0] cmd_rs2;
  logic [7:0] cmd_imm;
  logic       cmd_use_imm;
  logic       cmd_we;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_z;
  logic       res_c;
  logic       res_v;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] r_data;
  logic       r_z;
  logic       r_c;
  logic       r_v;
  int         waited;
  int         t0;
  int         t1;
  bit         got;

  rf_alu_engine #(
    .WIDTH(8),
    .NREGS(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_imm    (cmd_imm),
    .cmd_use_imm(cmd_use_imm),
    .cmd_we     (cmd_we),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_z      (res_z),
    .res_c      (res_c),
    .res_v      (res_v),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [7:0] d, input logic z, input logic c,
                         input logic v);
    chk({tag, ".data"}, {24'h0, r_data}, {24'h0, d});
    chk({tag, ".z"}, {31'h0, r_z}, {31'h0, z});
    chk({tag, ".c"}, {31'h0, r_c}, {31'h0, c});
    chk({tag, ".v"}, {31'h0, r_v}, {31'h0, v});
  endtask

  task automatic chk_dbg(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    chk(tag, {24'h0, dbg_data}, {24'h0, exp});
  endtask

  // Called at a negedge; drives one command and checks its 3-cycle latency.
  task automatic do_cmd(input string tag, input logic [2:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2, input logic [7:0] imm,
                        input logic use_imm, input logic we, output int wcnt);
    wcnt = 0;
    while (!cmd_ready && wcnt < 20) begin
      @(negedge clk);
      wcnt++;
    end
    if (!cmd_ready) begin
      chk({tag, ".ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_rd      = rd;
    cmd_rs1     = rs1;
    cmd_rs2     = rs2;
    cmd_imm     = imm;
    cmd_use_imm = use_imm;
    cmd_we      = we;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk({tag, ".read_ready"}, {31'h0, cmd_ready}, 32'd0);
    chk({tag, ".read_rv"}, {31'h0, res_valid}, 32'd0);
    @(negedge clk);
    chk({tag, ".exec_rv"}, {31'h0, res_valid}, 32'd0);
    @(negedge clk);
    chk({tag, ".wb_rv"}, {31'h0, res_valid}, 32'd1);
    r_data = res_data;
    r_z    = res_z;
    r_c    = res_c;
    r_v    = res_v;
    @(negedge clk);
    chk({tag, ".idle_rv"}, {31'h0, res_valid}, 32'd0);
    chk({tag, ".idle_ready"}, {31'h0, cmd_ready}, 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = 3'b000;
    cmd_rd      = 3'd0;
    cmd_rs1     = 3'd0;
    cmd_rs2     = 3'd0;
    cmd_imm     = 8'h00;
    cmd_use_imm = 1'b0;
    cmd_we      = 1'b0;
    dbg_addr    = 3'd0;
    #1;
    chk("rst.ready", {31'h0, cmd_ready}, 32'd1);
    chk("rst.rv", {31'h0, res_valid}, 32'd0);
    chk("rst.data", {24'h0, res_data}, 32'd0);
    chk("rst.flags", {29'h0, res_z, res_c, res_v}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_dbg($sformatf("rst.dbg%0d", i), 3'(i), 8'h00);
    end
    @(negedge clk);

    // Immediates then register-register add
    do_cmd("imm_r1", ALU_ADD, 3'd1, 3'd0, 3'd0, 8'h05, 1'b1, 1'b1, waited);
    chk_res("imm_r1", 8'h05, 1'b0, 1'b0, 1'b0);
    do_cmd("imm_r2", ALU_ADD, 3'd2, 3'd0, 3'd0, 8'h03, 1'b1, 1'b1, waited);
    do_cmd("add_r3", ALU_ADD, 3'd3, 3'd1, 3'd2, 8'h00, 1'b0, 1'b1, waited);
    chk_res("add_r3", 8'h08, 1'b0, 1'b0, 1'b0);
    chk_dbg("dbg_r3", 3'd3, 8'h08);

    // SUB / SLT
    do_cmd("sub_r4", ALU_SUB, 3'd4, 3'd2, 3'd1, 8'h00, 1'b0, 1'b1, waited);
    chk_res("sub_r4", 8'hFE, 1'b0, 1'b0, 1'b0);
    chk_dbg("dbg_r4", 3'd4, 8'hFE);
    do_cmd("slt_r5", ALU_SLT, 3'd5, 3'd2, 3'd1, 8'h00, 1'b0, 1'b1, waited);
    chk_res("slt_r5", 8'h01, 1'b0, 1'b0, 1'b0);
    chk_dbg("dbg_r5", 3'd5, 8'h01);
    do_cmd("sub_self", ALU_SUB, 3'd6, 3'd1, 3'd1, 8'h00, 1'b0, 1'b1, waited);
    chk_res("sub_self", 8'h00, 1'b1, 1'b1, 1'b0);

    // Overflow, carry, shifts and logic ops
    do_cmd("ld_7f", ALU_ADD, 3'd6, 3'd0, 3'd0, 8'h7F, 1'b1, 1'b1, waited);
    do_cmd("add_ovf", ALU_ADD, 3'd7, 3'd6, 3'd0, 8'h01, 1'b1, 1'b1, waited);
    chk_res("add_ovf", 8'h80, 1'b0, 1'b0, 1'b1);
    do_cmd("ld_ff", ALU_ADD, 3'd6, 3'd0, 3'd0, 8'hFF, 1'b1, 1'b1, waited);
    do_cmd("add_cy", ALU_ADD, 3'd7, 3'd6, 3'd0, 8'h01, 1'b1, 1'b1, waited);
    chk_res("add_cy", 8'h00, 1'b1, 1'b1, 1'b0);
    do_cmd("ld_81", ALU_ADD, 3'd6, 3'd0, 3'd0, 8'h81, 1'b1, 1'b1, waited);
    do_cmd("sll", ALU_SLL, 3'd7, 3'd6, 3'd0, 8'h01, 1'b1, 1'b1, waited);
    chk_res("sll", 8'h02, 1'b0, 1'b0, 1'b0);
    do_cmd("and", ALU_AND, 3'd7, 3'd6, 3'd0, 8'h0F, 1'b1, 1'b1, waited);
    chk_res("and", 8'h01, 1'b0, 1'b0, 1'b0);
    do_cmd("xor", ALU_XOR, 3'd7, 3'd6, 3'd0, 8'hFF, 1'b1, 1'b1, waited);
    chk_res("xor", 8'h7E, 1'b0, 1'b0, 1'b0);
    do_cmd("or", ALU_OR, 3'd7, 3'd6, 3'd0, 8'h70, 1'b1, 1'b1, waited);
    chk_res("or", 8'hF1, 1'b0, 1'b0, 1'b0);
    do_cmd("ld_80", ALU_ADD, 3'd6, 3'd0, 3'd0, 8'h80, 1'b1, 1'b1, waited);
    do_cmd("srl", ALU_SRL, 3'd7, 3'd6, 3'd0, 8'h07, 1'b1, 1'b1, waited);
    chk_res("srl", 8'h01, 1'b0, 1'b0, 1'b0);
    chk_dbg("dbg_r7", 3'd7, 8'h01);

    // Write to r0 is dropped but still reported
    do_cmd("add_r0", ALU_ADD, 3'd0, 3'd1, 3'd0, 8'h05, 1'b1, 1'b1, waited);
    chk_res("add_r0", 8'h0A, 1'b0, 1'b0, 1'b0);
    chk_dbg("dbg_r0", 3'd0, 8'h00);
    @(negedge clk);

    // Back-to-back with cmd_valid held high
    cmd_valid   = 1'b1;
    cmd_op      = ALU_ADD;
    cmd_rd      = 3'd7;
    cmd_rs1     = 3'd0;
    cmd_imm     = 8'h11;
    cmd_use_imm = 1'b1;
    cmd_we      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t0  = cyc;
    t1  = 0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      if (cmd_ready) begin
        @(posedge clk);
        @(negedge clk);
        t1  = cyc;
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    cmd_valid = 1'b0;
    chk("b2b.spacing", t1 - t0, 32'd4);
    repeat (2) @(negedge clk);
    chk("b2b.wb_rv", {31'h0, res_valid}, 32'd1);
    chk("b2b.data", {24'h0, res_data}, 32'h11);
    @(negedge clk);
    chk("b2b.ready", {31'h0, cmd_ready}, 32'd1);

    // Reset during EXEC aborts the command
    cmd_valid   = 1'b1;
    cmd_op      = ALU_ADD;
    cmd_rd      = 3'd6;
    cmd_rs1     = 3'd0;
    cmd_imm     = 8'h55;
    cmd_use_imm = 1'b1;
    cmd_we      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort.ready", {31'h0, cmd_ready}, 32'd1);
    chk("abort.rv", {31'h0, res_valid}, 32'd0);
    @(negedge clk);
    chk("abort.rv2", {31'h0, res_valid}, 32'd0);
    rst = 1'b0;
    chk_dbg("abort.dbg_r6", 3'd6, 8'h00);
    do_cmd("post_abort", ALU_ADD, 3'd1, 3'd0, 3'd0, 8'h22, 1'b1, 1'b1, waited);
    chk("post_abort.wait", waited, 32'd0);
    chk_res("post_abort", 8'h22, 1'b0, 1'b0, 1'b0);
    chk_dbg("post_abort.dbg_r1", 3'd1, 8'h22);
    do_cmd("sub_borrow", ALU_SUB, 3'd2, 3'd0, 3'd0, 8'h01, 1'b1, 1'b1, waited);
    chk_res("sub_borrow", 8'hFF, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
